// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Transmit holding FIFO between the APB register interface and the UART
// transmitter. Bytes written by software are queued here. The transmitter pops
// them one at a time with an active-low strobe and gets back registered data.
// Status flags are decoded directly from the registered entry count.

module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     rd_n,
  input  logic                     clr_ovf,
  output logic [WIDTH-1:0]         data_out,
  output logic                     empty,
  output logic                     full,
  output logic                     tx_rdy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             overflow_q, overflow_d;

  logic push;
  logic pop;

  // Decode pop/push; a pop frees a slot so a write to a full FIFO can still land
  always_comb begin
    pop  = !rd_n && (count_q != '0);
    push = wr_en && ((count_q != FULL_CNT) || pop);
  end

  // Next-state for pointers, count, popped data and the sticky overflow flag
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    overflow_d = overflow_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    if (pop) begin
      rd_ptr_d   = rd_ptr_q + 1'b1;
      data_out_d = mem_q[rd_ptr_q];
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A dropped write wins over a clear arriving in the same cycle
    if (wr_en && !push) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  // Control and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; no reset because entries are always written before being read
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out = data_out_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign tx_rdy   = (count_q != FULL_CNT);
  assign level    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo (DEPTH=16, WIDTH=8).
// Inputs change just after the falling edge; outputs are checked on the
// following falling edge, after the rising edge has acted on them.

module tb_uart_tx_fifo;

  logic       clk;
  logic       reset_n;
  logic       wr_en;
  logic [7:0] data_in;
  logic       rd_n;
  logic       clr_ovf;
  logic [7:0] data_out;
  logic       empty;
  logic       full;
  logic       tx_rdy;
  logic [4:0] level;
  logic       overflow;

  int total;
  int bad;

  typedef struct {
    logic       wr;
    logic [7:0] din;
    logic       rd_n;
    logic       clr;
    logic       e_empty;
    logic       e_full;
    logic [4:0] e_level;
    logic [7:0] e_dout;
    logic       e_ovf;
  } vec_t;

  vec_t vecs [17];

  uart_tx_fifo #(.DEPTH(16), .WIDTH(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .data_in  (data_in),
    .rd_n     (rd_n),
    .clr_ovf  (clr_ovf),
    .data_out (data_out),
    .empty    (empty),
    .full     (full),
    .tx_rdy   (tx_rdy),
    .level    (level),
    .overflow (overflow)
  );

  // 100 MHz free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkField(input string name, input string field,
                            input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s.%s actual=%0h expected=%0h", name, field, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic e_empty,
                             input logic e_full, input logic [4:0] e_level,
                             input logic [7:0] e_dout, input logic e_ovf);
    checkField(name, "empty",    int'(empty),    int'(e_empty));
    checkField(name, "full",     int'(full),     int'(e_full));
    checkField(name, "tx_rdy",   int'(tx_rdy),   int'(!e_full));
    checkField(name, "level",    int'(level),    int'(e_level));
    checkField(name, "data_out", int'(data_out), int'(e_dout));
    checkField(name, "overflow", int'(overflow), int'(e_ovf));
  endtask

  // Drive one cycle of inputs, then wait for the next falling edge
  task automatic applyStimulus(input logic wr, input logic [7:0] din,
                               input logic rd, input logic clr);
    wr_en   = wr;
    data_in = din;
    rd_n    = rd;
    clr_ovf = clr;
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;

    //            wr    din    rd_n  clr   empty full  level  dout   ovf
    vecs[0]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 8'h00, 1'b0};
    vecs[2]  = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 8'h00, 1'b0};
    vecs[3]  = '{1'b1, 8'hA3, 1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 8'h00, 1'b0};
    vecs[4]  = '{1'b1, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 8'h00, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 8'h55, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 8'h55, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 8'h55, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 8'h55, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 8'hA3, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 8'hA3, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 8'hA3, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 8'hA3, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 8'h0F, 1'b0};
    vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 8'h0F, 1'b0};
    vecs[15] = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 8'h0F, 1'b0};
    vecs[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 8'h3C, 1'b0};

    reset_n = 1'b0;
    wr_en   = 1'b0;
    data_in = 8'h00;
    rd_n    = 1'b1;
    clr_ovf = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("in_reset", 1'b1, 1'b0, 5'd0, 8'h00, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);

    // Table: empty reads, three-byte write/read, write+read on empty
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].din, vecs[i].rd_n, vecs[i].clr);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_empty, vecs[i].e_full,
                  vecs[i].e_level, vecs[i].e_dout, vecs[i].e_ovf);
    end

    // Fill to DEPTH with 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b1, 1'b0);
      checkOutput($sformatf("fill%0d", i), 1'b0, (i == 15), 5'(i + 1),
                  8'h3C, 1'b0);
    end

    // 17th write is dropped and sets overflow
    applyStimulus(1'b1, 8'hFF, 1'b1, 1'b0);
    checkOutput("ovf_set", 1'b0, 1'b1, 5'd16, 8'h3C, 1'b1);

    // Dropped write and clear in the same cycle: set wins
    applyStimulus(1'b1, 8'hEE, 1'b1, 1'b1);
    checkOutput("ovf_prio", 1'b0, 1'b1, 5'd16, 8'h3C, 1'b1);

    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("ovf_clr", 1'b0, 1'b1, 5'd16, 8'h3C, 1'b0);

    // Full with simultaneous write and pop: both happen
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
    checkOutput("full_wr_rd", 1'b0, 1'b1, 5'd16, 8'h00, 1'b0);

    // Drain: 0x01..0x0F then 0x77, never 0xFF or 0xEE
    for (int i = 1; i < 16; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput($sformatf("drain%0d", i), 1'b0, 1'b0, 5'(16 - i),
                  8'(i), 1'b0);
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("drain_last", 1'b1, 1'b0, 5'd0, 8'h77, 1'b0);

    // rd_n held low for three cycles pops only while entries remain
    applyStimulus(1'b1, 8'h11, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b1, 1'b0);
    checkOutput("hold_pre", 1'b0, 1'b0, 5'd2, 8'h77, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("hold_1", 1'b0, 1'b0, 5'd1, 8'h11, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("hold_2", 1'b1, 1'b0, 5'd0, 8'h22, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("hold_3", 1'b1, 1'b0, 5'd0, 8'h22, 1'b0);

    // Level 5 with overflow irrelevant, then asynchronous reset mid-cycle
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b1, 1'b0);
    end
    idle();
    checkOutput("pre_reset", 1'b0, 1'b0, 5'd5, 8'h22, 1'b0);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset", 1'b1, 1'b0, 5'd0, 8'h00, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 8'hC5, 1'b1, 1'b0);
    checkOutput("post_rst_wr", 1'b0, 1'b0, 5'd1, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("post_rst_rd", 1'b1, 1'b0, 5'd0, 8'hC5, 1'b0);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
